// File: rtl/huff_pkg.sv
// Shared constants and FSM encoding for the Huffman bit-buffer feed controller.
package huff_pkg;

  localparam int HUFF_MAX_CODE = 9;
  localparam int HUFF_WORD_W   = 8;
  localparam int HUFF_CHUNK_W  = 4;
  localparam int HUFF_OCC_W    = $clog2(HUFF_MAX_CODE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } huff_state_e;

endpackage

// File: rtl/huff_chunk_sel.sv
// Picks the next load chunk: min(CHUNK_W, rem) bits from the top of the word,
// right-aligned so the buffer sees them in its low ld_len bits.
module huff_chunk_sel #(
  parameter  int WORD_W  = 8,
  parameter  int CHUNK_W = 4,
  localparam int REM_W   = $clog2(WORD_W + 1),
  localparam int LEN_W   = $clog2(CHUNK_W + 1)
) (
  input  logic [WORD_W-1:0]  word_sr,
  input  logic [REM_W-1:0]   rem,
  output logic [LEN_W-1:0]   len,
  output logic [CHUNK_W-1:0] bits
);

  logic [CHUNK_W-1:0] head;
  assign head = word_sr[WORD_W-1 -: CHUNK_W];

  always_comb begin
    len  = (rem >= REM_W'(CHUNK_W)) ? LEN_W'(CHUNK_W) : LEN_W'(rem);
    bits = head >> (LEN_W'(CHUNK_W) - len);
  end

endmodule

// File: rtl/huff_feed_ctrl.sv
// Feeds byte-wide stream words into the decoder bit buffer in <=CHUNK_W loads,
// mirroring occupancy so a load never coincides with a consume.
module huff_feed_ctrl
  import huff_pkg::*;
#(
  parameter  int MAX_CODE = HUFF_MAX_CODE,
  parameter  int WORD_W   = HUFF_WORD_W,
  parameter  int CHUNK_W  = HUFF_CHUNK_W,
  localparam int OCC_W    = $clog2(MAX_CODE + 1),
  localparam int REM_W    = $clog2(WORD_W + 1),
  localparam int LEN_W    = $clog2(CHUNK_W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_valid,
  input  logic               s_last,
  input  logic [REM_W-1:0]   s_last_bits,
  output logic               s_ready,
  input  logic               cons_valid,
  input  logic [OCC_W-1:0]   cons_len,
  output logic               ld_valid,
  output logic [CHUNK_W-1:0] ld_bits,
  output logic [LEN_W-1:0]   ld_len,
  output logic [OCC_W-1:0]   occupancy,
  output logic               eos,
  output logic               err_underflow
);

  localparam int SUM_W = OCC_W + 1;

  huff_state_e        state_q, state_d;
  logic [WORD_W-1:0]  word_sr_q, word_sr_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               held_last_q, held_last_d;
  logic [OCC_W-1:0]   occupancy_q, occupancy_d;
  logic               err_q, err_d;
  logic               eos_q, eos_d;

  logic [LEN_W-1:0]   chunk_len;
  logic [CHUNK_W-1:0] chunk_bits;
  logic [SUM_W-1:0]   occ_sum;
  logic               fits, last_chunk, accept, cons_ok, cons_bad;
  logic [REM_W-1:0]   last_cnt;

  huff_chunk_sel #(.WORD_W(WORD_W), .CHUNK_W(CHUNK_W)) u_chunk_sel (
    .word_sr (word_sr_q),
    .rem     (rem_q),
    .len     (chunk_len),
    .bits    (chunk_bits)
  );

  assign ld_bits       = chunk_bits;
  assign ld_len        = chunk_len;
  assign occupancy     = occupancy_q;
  assign eos           = eos_q;
  assign err_underflow = err_q;

  // Sum kept one bit wider so a full buffer plus a chunk cannot wrap into "fits".
  assign occ_sum    = SUM_W'(occupancy_q) + SUM_W'(chunk_len);
  assign fits       = occ_sum <= SUM_W'(MAX_CODE);
  assign last_chunk = REM_W'(chunk_len) == rem_q;
  assign accept     = s_valid && s_ready;
  assign cons_ok    = cons_valid && (cons_len != '0) && (cons_len <= occupancy_q);
  assign cons_bad   = cons_valid && (cons_len > occupancy_q);
  assign last_cnt   = ((s_last_bits == '0) || (s_last_bits > REM_W'(WORD_W)))
                      ? REM_W'(WORD_W) : s_last_bits;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = FEED;
      FEED:  if (ld_valid && last_chunk)
               state_d = held_last_q ? DRAIN : (accept ? FEED : IDLE);
      DRAIN: if (occupancy_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Consume wins over load; reset forces both strobes low asynchronously.
  always_comb begin
    ld_valid = 1'b0;
    s_ready  = 1'b0;
    if (reset) begin
      ld_valid = (state_q == FEED) && !cons_valid && fits;
      s_ready  = (state_q == IDLE) || (ld_valid && last_chunk && !held_last_q);
    end
  end

  always_comb begin
    word_sr_d   = word_sr_q;
    rem_d       = rem_q;
    held_last_d = held_last_q;
    occupancy_d = occupancy_q;
    err_d       = err_q || cons_bad;
    eos_d       = (state_q == DRAIN) && (occupancy_q == '0);
    if (accept) begin
      word_sr_d   = s_data;
      rem_d       = s_last ? last_cnt : REM_W'(WORD_W);
      held_last_d = s_last;
    end else if (ld_valid) begin
      word_sr_d = word_sr_q << chunk_len;
      rem_d     = rem_q - REM_W'(chunk_len);
    end
    if (ld_valid)     occupancy_d = occupancy_q + OCC_W'(chunk_len);
    else if (cons_ok) occupancy_d = occupancy_q - cons_len;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_sr_q   <= '0;
      rem_q       <= '0;
      held_last_q <= 1'b0;
      occupancy_q <= '0;
      err_q       <= 1'b0;
      eos_q       <= 1'b0;
    end else begin
      word_sr_q   <= word_sr_d;
      rem_q       <= rem_d;
      held_last_q <= held_last_d;
      occupancy_q <= occupancy_d;
      err_q       <= err_d;
      eos_q       <= eos_d;
    end
  end

endmodule

// File: tb/tb_huff_feed_ctrl.sv
// Bench for huff_feed_ctrl: directed and random traffic against a bit-queue
// model of the stream and buffer occupancy.
module tb_huff_feed_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0, s_last = 1'b0;
  logic [3:0] s_last_bits = '0;
  logic       s_ready;
  logic       cons_valid = 1'b0;
  logic [3:0] cons_len = '0;
  logic       ld_valid;
  logic [3:0] ld_bits;
  logic [2:0] ld_len;
  logic [3:0] occupancy;
  logic       eos, err_underflow;

  int n_chk = 0;
  int n_err = 0;

  // Model: pending stream bits of the held word, buffer occupancy, flags.
  int q[$];
  int m_occ;
  bit m_last, m_drain, m_eos, m_err;

  huff_feed_ctrl dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_last_bits(s_last_bits),
    .s_ready(s_ready),
    .cons_valid(cons_valid), .cons_len(cons_len),
    .ld_valid(ld_valid), .ld_bits(ld_bits), .ld_len(ld_len),
    .occupancy(occupancy), .eos(eos), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_occ = 0; m_last = 0; m_drain = 0; m_eos = 0; m_err = 0;
  endtask

  task automatic step(input bit sv, input logic [7:0] d, input bit sl, input logic [3:0] lb,
                      input bit cv, input logic [3:0] cl);
    int n, nb, ebits;
    bit exp_ld, exp_rdy, nxt_eos;
    @(negedge clk);
    s_valid = sv; s_data = d; s_last = sl; s_last_bits = lb;
    cons_valid = cv; cons_len = cl;
    #2;
    n      = (q.size() < 4) ? q.size() : 4;
    exp_ld = (q.size() > 0) && !cv && (m_occ + n <= 9);
    exp_rdy = ((q.size() == 0) && !m_drain) || (exp_ld && n == q.size() && !m_last);
    ebits = 0;
    for (int i = 0; i < n; i++) ebits = ebits * 2 + q[i];
    chk("ld_valid", ld_valid, exp_ld);
    chk("s_ready", s_ready, exp_rdy);
    chk("occupancy", occupancy, m_occ);
    chk("occ_max", occupancy <= 4'd9, 1);
    chk("eos", eos, m_eos);
    chk("err_underflow", err_underflow, m_err);
    if (exp_ld) begin
      chk("ld_len", ld_len, n);
      chk("ld_bits", ld_bits, ebits);
    end
    nxt_eos = m_drain && (m_occ == 0);
    if (nxt_eos) m_drain = 0;
    if (exp_ld) begin
      for (int i = 0; i < n; i++) void'(q.pop_front());
      m_occ += n;
      if (q.size() == 0 && m_last) m_drain = 1;
    end else if (cv && cl != 0) begin
      if (cl <= m_occ) m_occ -= cl;
      else m_err = 1;
    end
    if (sv && exp_rdy) begin
      nb = (!sl || lb == 0 || lb > 8) ? 8 : int'(lb);
      for (int i = 0; i < nb; i++) q.push_back(int'(d[7 - i]));
      m_last = sl;
    end
    m_eos = nxt_eos;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 8'h00, 0, 4'd0, 0, 4'd0);
  endtask

  task automatic cons(input int len);
    step(0, 8'h00, 0, 4'd0, 1, 4'(len));
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_eos", eos, 0);
    chk("rst_err", err_underflow, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 0xB6 into an empty buffer, then 0xF0 against occupancy 8.
    step(1, 8'hB6, 0, 4'd0, 0, 4'd0);
    idle(2);
    step(1, 8'hF0, 0, 4'd0, 0, 4'd0);
    idle(2);
    cons(3);
    idle(2);
    cons(4);
    cons(1);
    idle(1);
    cons(8);
    // Final partial byte 0xA8 with 5 valid bits, then drain to eos.
    step(1, 8'hA8, 1, 4'd5, 0, 4'd0);
    idle(4);
    cons(5);
    idle(3);
    step(1, 8'h5C, 1, 4'd3, 0, 4'd0);
    idle(2);
    cons(3);
    idle(3);

    for (int i = 0; i < 3000; i++)
      step(($urandom % 2) == 1, 8'($urandom), ($urandom % 8) == 0, 4'($urandom),
           ($urandom % 3) == 0, 4'($urandom_range(m_occ, 0)));

    // Asynchronous reset while a word is half loaded.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    step(1, 8'hB6, 0, 4'd0, 0, 4'd0);
    idle(1);
    @(negedge clk);
    s_valid = 1'b0; cons_valid = 1'b0;
    #1;
    chk("pre_rst_ld_valid", ld_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_ld_valid", ld_valid, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_ld_bits", ld_bits, 0);
    chk("mid_rst_ld_len", ld_len, 0);
    chk("mid_rst_occupancy", occupancy, 0);
    chk("mid_rst_eos", eos, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    idle(3);

    // Underflow at occupancy 2 is sticky and leaves occupancy alone.
    step(1, 8'hC0, 1, 4'd2, 0, 4'd0);
    idle(2);
    cons(3);
    idle(2);
    cons(2);
    idle(3);
    chk("err_sticky", err_underflow, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
